bus_route_ctrl: RTL and testbench

Sequencer for the 8-bit two-way bus demultiplexer in the ALU result path. It accepts one result word per handshake with a destination tag, holds it in a one-entry register, and drives the demux select. It presents the word on the chosen output channel with valid/ready flow control and keeps the unselected channel idle. It sits between the ALU result stage and its two consumers (o1 = destination tag 1, o2 = destination tag 0, the same polarity as the demux select).

---
 rtl/bus_route_ctrl.sv | 134 +++++++++++++
 tb/tb_bus_route_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_route_ctrl.sv
// -----------------------------------------------------------------------------
// bus_route_ctrl
//
// Sequencer for the two-way result-bus demultiplexer. One result word plus a
// destination tag is accepted per handshake and kept in a single holding
// register. The word is then presented on the selected output channel with
// valid/ready flow control. The unselected channel stays idle (data 0, valid 0).
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_data/in_dest     : result word and tag (1 -> o1, 0 -> o2)
//   in_valid/in_ready   : input handshake
//   flush               : synchronous discard of the held word
//   sel                 : demux select, equals the held destination tag
//   o1_* / o2_*         : output channels (data, valid, ready)
//   busy                : a word is held
//   cnt1/cnt2           : delivered-word counters (only with BUS_ROUTE_CNT_EN)
//
// Optional feature macro: BUS_ROUTE_CNT_EN adds the cnt1/cnt2 ports and counters.
// -----------------------------------------------------------------------------
module bus_route_ctrl #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] in_data,
    input  logic         in_dest,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic         sel,
    output logic [w-1:0] o1_data,
    output logic         o1_valid,
    input  logic         o1_ready,
    output logic [w-1:0] o2_data,
    output logic         o2_valid,
    input  logic         o2_ready,
    output logic         busy
`ifdef BUS_ROUTE_CNT_EN
    ,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2
`endif
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [w-1:0] data_q, data_d;
    logic         dest_q, dest_d;

    logic sel_ready;
    logic xfer;
    logic accept;

    always_comb begin
        // Only the selected channel's ready matters; the other one is ignored.
        sel_ready = dest_q ? o1_ready : o2_ready;
        // flush wins over a transfer, so a flushed handshake is not a delivery.
        xfer      = (state_q == HOLD) && sel_ready && !flush;
        // Pass-through accept in HOLD: a new word can load in the same cycle
        // the held word leaves, giving one word per cycle.
        in_ready  = !rst && !flush && ((state_q == IDLE) || sel_ready);
        accept    = in_valid && in_ready;

        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        if (flush) begin
            state_d = IDLE;
            data_d  = '0;
            dest_d  = 1'b0;
        end else if (accept) begin
            state_d = HOLD;
            data_d  = in_data;
            dest_d  = in_dest;
        end else if (xfer) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            dest_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
        end
    end

    // Outputs come straight from registered state: no input-to-output path.
    always_comb begin
        busy     = (state_q == HOLD);
        sel      = dest_q;
        o1_valid = busy && dest_q;
        o2_valid = busy && !dest_q;
        o1_data  = o1_valid ? data_q : '0;
        o2_data  = o2_valid ? data_q : '0;
    end

`ifdef BUS_ROUTE_CNT_EN
    logic [7:0] cnt1_q, cnt1_d;
    logic [7:0] cnt2_q, cnt2_d;

    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        // Counters wrap naturally at 8 bits and ignore flush.
        if (xfer && dest_q) begin
            cnt1_d = cnt1_q + 8'd1;
        end
        if (xfer && !dest_q) begin
            cnt2_d = cnt2_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q <= 8'd0;
            cnt2_q <= 8'd0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_bus_route_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_route_ctrl
//
// Self-checking bench for bus_route_ctrl. A behavioural model (held flag, word,
// tag and delivery counts) predicts every output each cycle. Directed scenarios
// are followed by randomized traffic, and literal expectations pin key points.
// Counter checks are compiled in only with BUS_ROUTE_CNT_EN.
// -----------------------------------------------------------------------------
module tb_bus_route_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_dest;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic         sel;
    logic [W-1:0] o1_data;
    logic         o1_valid;
    logic         o1_ready;
    logic [W-1:0] o2_data;
    logic         o2_valid;
    logic         o2_ready;
    logic         busy;
`ifdef BUS_ROUTE_CNT_EN
    logic [7:0]   cnt1;
    logic [7:0]   cnt2;
`endif

    bus_route_ctrl #(.w(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_dest  (in_dest),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .sel      (sel),
        .o1_data  (o1_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o2_data  (o2_data),
        .o2_valid (o2_valid),
        .o2_ready (o2_ready),
        .busy     (busy)
`ifdef BUS_ROUTE_CNT_EN
        ,
        .cnt1     (cnt1),
        .cnt2     (cnt2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model
    bit         m_held;
    bit [W-1:0] m_data;
    bit         m_dest;
    int         m_cnt1;
    int         m_cnt2;
    bit         m_just_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare just after, update model at posedge.
    task automatic step(input bit r, input bit f, input bit v, input bit d,
                        input bit [W-1:0] x, input bit r1, input bit r2);
        bit exp_ready;
        bit sel_rdy;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; in_dest = d; in_data = x;
        o1_ready = r1; o2_ready = r2;
        #1;
        sel_rdy   = m_dest ? r1 : r2;
        exp_ready = !r && !f && (!m_held || sel_rdy);
        chk("in_ready", in_ready, exp_ready);
        chk("busy", busy, m_held);
        chk("o1_valid", o1_valid, m_held && m_dest);
        chk("o2_valid", o2_valid, m_held && !m_dest);
        chk("o1_data", o1_data, (m_held && m_dest) ? m_data : '0);
        chk("o2_data", o2_data, (m_held && !m_dest) ? m_data : '0);
        if (m_held) chk("sel", sel, m_dest);
        else if (m_just_rst) chk("sel_rst", sel, 1'b0);
`ifdef BUS_ROUTE_CNT_EN
        chk("cnt1", cnt1, m_cnt1[7:0]);
        chk("cnt2", cnt2, m_cnt2[7:0]);
`endif
        @(posedge clk);
        m_just_rst = 1'b0;
        if (r) begin
            m_held = 0; m_data = '0; m_dest = 0; m_cnt1 = 0; m_cnt2 = 0;
            m_just_rst = 1'b1;
        end else if (f) begin
            m_held = 0;
        end else begin
            if (m_held && sel_rdy) begin
                if (m_dest) m_cnt1 = (m_cnt1 + 1) % 256;
                else        m_cnt2 = (m_cnt2 + 1) % 256;
                m_held = 0;
            end
            if (v && exp_ready) begin
                m_held = 1; m_data = x; m_dest = d;
            end
        end
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; in_dest = 0; in_data = '0;
        o1_ready = 0; o2_ready = 0;
        m_held = 0; m_data = '0; m_dest = 0; m_cnt1 = 0; m_cnt2 = 0; m_just_rst = 0;
        @(posedge clk);
        m_just_rst = 1'b1;

        // Reset values and in_ready held low under reset
        step(1, 0, 1, 1, 8'hFF, 1, 1);
        step(1, 0, 0, 0, 8'h00, 1, 1);
        #1;
        chk("rst_sel", sel, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Single word to o2
        step(0, 0, 1, 0, 8'hB5, 0, 1);
        #1;
        chk("t1_o2_valid", o2_valid, 1'b1);
        chk("t1_o2_data", o2_data, 8'hB5);
        chk("t1_sel", sel, 1'b0);
        chk("t1_o1_valid", o1_valid, 1'b0);
        chk("t1_o1_data", o1_data, 8'h00);
        step(0, 0, 0, 0, 8'h00, 0, 1);
        #1;
        chk("t1_idle", busy, 1'b0);
`ifdef BUS_ROUTE_CNT_EN
        chk("t1_cnt2", cnt2, 8'd1);
`endif

        // Backpressure on o1 for 4 cycles
        step(0, 0, 1, 1, 8'h3C, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 8'h00, 0, 1);
            #1;
            chk("bp_o1_data", o1_data, 8'h3C);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        step(0, 0, 0, 0, 8'h00, 1, 1);
        #1;
        chk("bp_done", busy, 1'b0);
`ifdef BUS_ROUTE_CNT_EN
        chk("bp_cnt1", cnt1, 8'd1);
`endif

        // Back-to-back alternating destinations at full throughput
        step(0, 0, 1, 1, 8'hA1, 1, 1);
        #1; chk("alt1_o1", o1_data, 8'hA1); chk("alt1_sel", sel, 1'b1);
        step(0, 0, 1, 0, 8'hA2, 1, 1);
        #1; chk("alt2_o2", o2_data, 8'hA2); chk("alt2_sel", sel, 1'b0);
        step(0, 0, 1, 1, 8'hA3, 1, 1);
        #1; chk("alt3_o1", o1_data, 8'hA3); chk("alt3_sel", sel, 1'b1);
        step(0, 0, 0, 0, 8'h00, 1, 1);

        // Flush while holding, with a simultaneous input
        step(0, 0, 1, 0, 8'h7E, 0, 0);
        step(0, 1, 1, 1, 8'h11, 0, 0);
        #1;
        chk("fl_busy", busy, 1'b0);
        chk("fl_o2_valid", o2_valid, 1'b0);
        chk("fl_o1_valid", o1_valid, 1'b0);
`ifdef BUS_ROUTE_CNT_EN
        chk("fl_cnt2", cnt2, 8'd2);
`endif

        // Reset while holding
        step(0, 0, 1, 1, 8'h5A, 0, 0);
        step(1, 0, 0, 0, 8'h00, 1, 1);
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_o1_valid", o1_valid, 1'b0);
        chk("mr_o1_data", o1_data, 8'h00);
        chk("mr_sel", sel, 1'b0);
`ifdef BUS_ROUTE_CNT_EN
        chk("mr_cnt1", cnt1, 8'd0);
`endif

        // 256 deliveries to o1 at full throughput
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 1, 1, 8'(i), 1, 0);
        end
        step(0, 0, 0, 0, 8'h00, 1, 0);
`ifdef BUS_ROUTE_CNT_EN
        #1;
        chk("wrap_cnt1", cnt1, 8'd0);
        chk("wrap_cnt2", cnt2, 8'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 1) == 1),
                 8'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
